// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the accumulator-machine control unit.
//   Opcode constants (IR[15:10]), controller state encoding, opcode
//   classes produced by ctrl_decode, accumulator source and ALU op codes.
//   Used by ctrl_decode and ctrl_fsm.
package ctrl_pkg;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_HLT = 6'b000001;
    localparam logic [5:0] OP_LDA = 6'b000010;
    localparam logic [5:0] OP_STA = 6'b000011;
    localparam logic [5:0] OP_ADD = 6'b000100;
    localparam logic [5:0] OP_SUB = 6'b000101;
    localparam logic [5:0] OP_AND = 6'b000110;
    localparam logic [5:0] OP_OR  = 6'b000111;
    localparam logic [5:0] OP_LDI = 6'b001000;
    localparam logic [5:0] OP_JMP = 6'b010000;
    localparam logic [5:0] OP_BRZ = 6'b010001;
    localparam logic [5:0] OP_PSH = 6'b011000;
    localparam logic [5:0] OP_POP = 6'b011001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ACC_SRC_ALU   = 2'd0,
        ACC_SRC_MEM   = 2'd1,
        ACC_SRC_IMM   = 2'd2,
        ACC_SRC_STACK = 2'd3
    } acc_src_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_HLT,
        CLS_ALU,
        CLS_LDI,
        CLS_JMP,
        CLS_BRZ,
        CLS_LDA,
        CLS_STA,
        CLS_PSH,
        CLS_POP
    } op_class_e;

    // Classes that take the MEM state instead of EXEC.
    function automatic logic is_mem_class(input op_class_e c);
        return (c == CLS_LDA) || (c == CLS_STA) || (c == CLS_PSH) || (c == CLS_POP);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode -- combinational opcode classifier.
//   opcode   in  6  decoded IR[15:10]
//   op_class out    instruction class steering the controller
//   alu_op   out    ALU operation for ALU-class opcodes (ADD otherwise)
//   legal    out 1  opcode is a recognised instruction
// Macro CTRL_STACK_OPS_EN: when defined PSH/POP are recognised, otherwise
// they fall into the illegal set.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_e  op_class,
    output alu_op_e    alu_op,
    output logic       legal
);

    always_comb begin
        op_class = CLS_NOP;
        alu_op   = ALU_ADD;
        legal    = 1'b1;
        case (opcode)
            OP_NOP: op_class = CLS_NOP;
            OP_HLT: op_class = CLS_HLT;
            OP_LDA: op_class = CLS_LDA;
            OP_STA: op_class = CLS_STA;
            OP_ADD: begin op_class = CLS_ALU; alu_op = ALU_ADD; end
            OP_SUB: begin op_class = CLS_ALU; alu_op = ALU_SUB; end
            OP_AND: begin op_class = CLS_ALU; alu_op = ALU_AND; end
            OP_OR:  begin op_class = CLS_ALU; alu_op = ALU_OR;  end
            OP_LDI: op_class = CLS_LDI;
            OP_JMP: op_class = CLS_JMP;
            OP_BRZ: op_class = CLS_BRZ;
`ifdef CTRL_STACK_OPS_EN
            OP_PSH: op_class = CLS_PSH;
            OP_POP: op_class = CLS_POP;
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm -- fetch/decode/execute controller for the accumulator machine.
//   clk, rst (async, active-low), start (leave IDLE), opcode (IR[15:10]),
//   zero (accumulator zero flag), mem_ready (memory handshake done).
//   Outputs: ir_w, pc_inc, pc_load, addr_sel (0=PC,1=BA), mem_rd, mem_wr,
//   acc_w, acc_src (0=ALU,1=mem,2=IMM,3=stack), alu_op (0=ADD,1=SUB,2=AND,
//   3=OR), sp_push, sp_pop, halted, illegal (one-cycle pulse in DECODE).
// Macro CTRL_STACK_OPS_EN enables PSH/POP; without it they are illegal and
// sp_push/sp_pop stay 0.
module ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_w,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       addr_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       acc_w,
    output logic [1:0] acc_src,
    output logic [1:0] alu_op,
    output logic       sp_push,
    output logic       sp_pop,
    output logic       halted,
    output logic       illegal
);

    state_e    state_q, state_d;
    op_class_e op_class;
    alu_op_e   dec_alu_op;
    logic      legal;

    ctrl_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class),
        .alu_op   (dec_alu_op),
        .legal    (legal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (!legal || op_class == CLS_NOP) state_d = ST_FETCH;
                else if (op_class == CLS_HLT)      state_d = ST_HALT;
                else if (is_mem_class(op_class))   state_d = ST_MEM;
                else                               state_d = ST_EXEC;
            end
            ST_EXEC:   state_d = ST_FETCH;
            // Stack ops complete in one cycle; LDA/STA wait on the handshake.
            ST_MEM: begin
                if (!(op_class == CLS_LDA || op_class == CLS_STA) || mem_ready)
                    state_d = ST_FETCH;
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the state register, so an asynchronous reset
    // clears every strobe in the same cycle. mem_rd/mem_wr depend only on
    // state and opcode, never on mem_ready.
    always_comb begin
        ir_w     = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        addr_sel = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        acc_w    = 1'b0;
        acc_src  = ACC_SRC_ALU;
        alu_op   = ALU_ADD;
        sp_push  = 1'b0;
        sp_pop   = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_rd = 1'b1;
                ir_w   = mem_ready;
                pc_inc = mem_ready;
            end
            ST_DECODE: illegal = ~legal;
            ST_EXEC: begin
                case (op_class)
                    CLS_ALU: begin acc_w = 1'b1; alu_op = dec_alu_op; end
                    CLS_LDI: begin acc_w = 1'b1; acc_src = ACC_SRC_IMM; end
                    CLS_JMP: pc_load = 1'b1;
                    CLS_BRZ: pc_load = zero;
                    default: ;
                endcase
            end
            ST_MEM: begin
                addr_sel = 1'b1;
                case (op_class)
                    CLS_LDA: begin
                        mem_rd  = 1'b1;
                        acc_w   = mem_ready;
                        acc_src = mem_ready ? ACC_SRC_MEM : ACC_SRC_ALU;
                    end
                    CLS_STA: mem_wr = 1'b1;
`ifdef CTRL_STACK_OPS_EN
                    CLS_PSH: sp_push = 1'b1;
                    CLS_POP: begin
                        sp_pop  = 1'b1;
                        acc_w   = 1'b1;
                        acc_src = ACC_SRC_STACK;
                    end
`endif
                    default: ;
                endcase
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm -- directed self-checking bench for ctrl_fsm.
//   An instruction-level model tracks where the current instruction is
//   relative to its fetch and predicts all outputs every cycle; literal
//   expectations at key cycles pin the model. Honours CTRL_STACK_OPS_EN.
module tb_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       ir_w, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_w;
    logic [1:0] acc_src, alu_op;
    logic       sp_push, sp_pop, halted, illegal;

    ctrl_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ir_w      (ir_w),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .addr_sel  (addr_sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .acc_w     (acc_w),
        .acc_src   (acc_src),
        .alu_op    (alu_op),
        .sp_push   (sp_push),
        .sp_pop    (sp_pop),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_w, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_w;
        logic [1:0] acc_src, alu_op;
        logic       sp_push, sp_pop, halted, illegal;
    } outs_t;

    outs_t dut_o, last;
    assign dut_o = {ir_w, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_w,
                    acc_src, alu_op, sp_push, sp_pop, halted, illegal};

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    localparam int K_NOP = 0, K_HLT = 1, K_ALU = 2, K_LDI = 3, K_JMP = 4,
                   K_BRZ = 5, K_LDA = 6, K_STA = 7, K_PSH = 8, K_POP = 9,
                   K_BAD = 10;

    // Model: m_run = left IDLE, m_halt = halted, m_pos = cycles since the
    // current instruction's fetch completed (0 while fetching).
    bit          m_run, m_halt;
    int unsigned m_pos;

    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'b000000: return K_NOP;
            6'b000001: return K_HLT;
            6'b000010: return K_LDA;
            6'b000011: return K_STA;
            6'b000100, 6'b000101, 6'b000110, 6'b000111: return K_ALU;
            6'b001000: return K_LDI;
            6'b010000: return K_JMP;
            6'b010001: return K_BRZ;
`ifdef CTRL_STACK_OPS_EN
            6'b011000: return K_PSH;
            6'b011001: return K_POP;
`endif
            default:   return K_BAD;
        endcase
    endfunction

    function automatic outs_t model_out();
        outs_t e = '0;
        int    k = kind_of(opcode);
        if (!m_run) return e;
        if (m_halt) begin
            e.halted = 1'b1;
            return e;
        end
        if (m_pos == 0) begin
            e.mem_rd = 1'b1;
            e.ir_w   = mem_ready;
            e.pc_inc = mem_ready;
        end else if (m_pos == 1) begin
            e.illegal = (k == K_BAD);
        end else begin
            case (k)
                K_ALU: begin e.acc_w = 1'b1; e.alu_op = 2'(opcode - 6'd4); end
                K_LDI: begin e.acc_w = 1'b1; e.acc_src = 2'd2; end
                K_JMP: e.pc_load = 1'b1;
                K_BRZ: e.pc_load = zero;
                K_LDA: begin
                    e.addr_sel = 1'b1;
                    e.mem_rd   = 1'b1;
                    e.acc_w    = mem_ready;
                    e.acc_src  = mem_ready ? 2'd1 : 2'd0;
                end
                K_STA: begin e.addr_sel = 1'b1; e.mem_wr = 1'b1; end
                K_PSH: begin e.addr_sel = 1'b1; e.sp_push = 1'b1; end
                K_POP: begin
                    e.addr_sel = 1'b1;
                    e.sp_pop   = 1'b1;
                    e.acc_w    = 1'b1;
                    e.acc_src  = 2'd3;
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_halt = 1'b0;
        m_pos  = 0;
    endtask

    task automatic model_step();
        int k = kind_of(opcode);
        if (!rst) begin
            model_reset();
            return;
        end
        if (!m_run) begin
            if (start) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (!m_halt) begin
            if (m_pos == 0) begin
                if (mem_ready) m_pos = 1;
            end else if (m_pos == 1) begin
                if (k == K_NOP || k == K_BAD) m_pos = 0;
                else if (k == K_HLT)          m_halt = 1'b1;
                else                          m_pos = 2;
            end else begin
                if (!(k == K_LDA || k == K_STA) || mem_ready) m_pos = 0;
            end
        end
    endtask

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: compare at negedge, advance model at posedge, drive at +1.
    task automatic tick();
        outs_t e;
        @(negedge clk);
        last = dut_o;
        e    = model_out();
        checks++;
        if (last !== e) begin
            errors++;
            $display("FAIL cycle%0d outputs: got %h expected %h", cyc, last, e);
        end
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    // Precondition: controller in FETCH. Completes the fetch at once, then
    // leaves the DECODE-cycle outputs in 'last'.
    task automatic fetch_decode(input logic [5:0] op);
        opcode    = op;
        mem_ready = 1'b1;
        tick();
        lit("fetch_ir_w", 16'(last.ir_w), 16'd1);
        mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t hv;
        rst = 1'b0; start = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        model_reset();
        tick(); tick();
        lit("reset_outs", 16'(last), 16'd0);

        // Release without start: nothing may move.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ready = i[0];
            tick();
        end
        lit("idle_no_start", 16'(last), 16'd0);

        // ADD with mem_ready high from the start.
        start = 1'b1; opcode = 6'b000100; mem_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        lit("add_c1_ir_w", 16'(last.ir_w), 16'd1);
        lit("add_c1_pc_inc", 16'(last.pc_inc), 16'd1);
        tick();
        lit("add_c2_decode", 16'(last), 16'd0);
        mem_ready = 1'b0;
        tick();
        lit("add_c3_acc_w", 16'(last.acc_w), 16'd1);
        lit("add_c3_alu_op", 16'(last.alu_op), 16'd0);
        tick();
        lit("add_c4_mem_rd", 16'(last.mem_rd), 16'd1);

        // LDA with three wait cycles.
        fetch_decode(6'b000010);
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("lda_wait_rd", 16'({last.mem_rd, last.addr_sel, last.acc_w}), 16'b110);
        end
        mem_ready = 1'b1;
        tick();
        lit("lda_done", 16'({last.mem_rd, last.addr_sel, last.acc_w, last.acc_src}), 16'b11101);

        // STA with two wait cycles.
        fetch_decode(6'b000011);
        tick(); tick();
        lit("sta_wait_wr", 16'(last.mem_wr), 16'd1);
        mem_ready = 1'b1;
        tick();
        lit("sta_done_wr", 16'(last.mem_wr), 16'd1);

        // BRZ not taken, then taken.
        zero = 1'b0;
        fetch_decode(6'b010001);
        tick();
        lit("brz_nz_pc_load", 16'(last.pc_load), 16'd0);
        fetch_decode(6'b010001);
        zero = 1'b1;
        tick();
        lit("brz_z_pc_load", 16'(last.pc_load), 16'd1);
        lit("brz_z_pc_inc", 16'(last.pc_inc), 16'd0);
        zero = 1'b0;

        // Remaining EXEC-class opcodes.
        fetch_decode(6'b001000);
        tick();
        lit("ldi_acc_src", 16'(last.acc_src), 16'd2);
        fetch_decode(6'b000111);
        tick();
        lit("or_alu_op", 16'(last.alu_op), 16'd3);
        fetch_decode(6'b000101); tick();
        fetch_decode(6'b000110); tick();
        fetch_decode(6'b010000);
        tick();
        lit("jmp_pc_load", 16'(last.pc_load), 16'd1);

        // NOP returns to FETCH straight after DECODE.
        fetch_decode(6'b000000);
        tick();
        lit("nop_refetch", 16'(last.mem_rd), 16'd1);

        // Unlisted opcode.
        fetch_decode(6'b111111);
        lit("bad_illegal", 16'(last.illegal), 16'd1);
        tick();
        lit("bad_refetch", 16'({last.mem_rd, last.illegal}), 16'b10);

        // Stack operations.
        fetch_decode(6'b011000);
`ifdef CTRL_STACK_OPS_EN
        lit("psh_legal", 16'(last.illegal), 16'd0);
        tick();
        lit("psh_push", 16'({last.sp_push, last.addr_sel}), 16'b11);
`else
        lit("psh_illegal", 16'({last.illegal, last.sp_push}), 16'b10);
        tick();
        lit("psh_refetch", 16'({last.mem_rd, last.sp_push}), 16'b10);
`endif
        fetch_decode(6'b011001);
        tick();

        // Reset in the middle of a FETCH wait.
        tick();
        lit("pre_rst_mem_rd", 16'(last.mem_rd), 16'd1);
        rst = 1'b0;
        model_reset();
        #1;
        lit("rst_fetch_all0", 16'(dut_o), 16'd0);
        tick();
        rst = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        lit("restart_mem_rd", 16'(last.mem_rd), 16'd1);

        // Reset in the middle of a STA wait.
        fetch_decode(6'b000011);
        tick();
        lit("sta_pre_rst", 16'(last.mem_wr), 16'd1);
        rst = 1'b0;
        model_reset();
        #1;
        lit("rst_mem_all0", 16'(dut_o), 16'd0);
        tick();
        rst = 1'b1;
        tick();

        // HLT: halted held with start and mem_ready toggling.
        start = 1'b1;
        tick();
        start = 1'b0;
        fetch_decode(6'b000001);
        hv = '0;
        hv.halted = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start     = i[0];
            mem_ready = 1'($urandom_range(0, 1));
            tick();
            lit("halt_hold", 16'(last), 16'(hv));
        end
        rst = 1'b0;
        model_reset();
        #1;
        lit("halt_rst_clear", 16'(dut_o.halted), 16'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have ports (clock and reset first): clk in 1 system clock; rst in 1 async active-low reset; start in 1 leave IDLE; opcode in 6 decoded IR[15:10]; zero in 1 accumulator-zero flag; mem_ready in 1 memory handshake done; ir_w out 1 IR write enable; pc_inc out 1 PC +1; pc_load out 1 PC <- BA; addr_sel out 1 0=PC, 1=BA; mem_rd out 1; mem_wr out 1; acc_w out 1 accumulator write; acc_src out 2 0=ALU,1=mem,2=IMM,3=stack; alu_op out 2 0=ADD,1=SUB,2=AND,3=OR; sp_push out 1; sp_pop out 1; halted out 1; illegal out 1 one-cycle pulse.
REQ-002 SHALL use one clock, clk; reset rst asynchronous, active-low (rst=0 clears all state immediately).

Function
REQ-003 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, HALT; all outputs registered-free Moore/Mealy decode from state plus opcode, no combinational path from mem_ready to mem_rd/mem_wr.
REQ-004 IDLE: all outputs 0; start=1 -> FETCH next cycle.
REQ-005 FETCH: addr_sel=0, mem_rd=1; holds until mem_ready=1; in the mem_ready cycle ir_w=1 and pc_inc=1 for exactly one cycle, then DECODE.
REQ-006 DECODE: one cycle, no strobes; -> MEM for LDA/STA/PSH/POP, -> HALT for HLT, -> FETCH for NOP, -> EXEC otherwise; unlisted opcode pulses illegal=1 and -> FETCH.
REQ-007 EXEC: one cycle; ADD/SUB/AND/OR: acc_w=1, acc_src=0, alu_op per opcode; LDI: acc_w=1, acc_src=2; JMP: pc_load=1; BRZ: pc_load=zero; -> FETCH.
REQ-008 MEM: addr_sel=1; LDA: mem_rd=1, acc_w=1 and acc_src=1 only in mem_ready cycle; STA: mem_wr=1 until mem_ready; PSH: sp_push=1 one cycle; POP: sp_pop=1, acc_w=1, acc_src=3 one cycle; -> FETCH after completion.
REQ-009 Memory strobe SHALL stay asserted and stable while mem_ready=0 (no timeout); mem_ready outside FETCH/MEM ignored.
REQ-010 HALT: halted=1, all other strobes 0; remains until reset; start ignored.
REQ-011 Latency: NOP 2 cycles after fetch, ALU/LDI/JMP/BRZ 3, memory ops 3 + wait cycles (mem_ready=1 same cycle gives zero wait).
REQ-012 ir_w and pc_inc SHALL never assert outside FETCH; pc_inc and pc_load never together.

Reset
REQ-013 rst=0 SHALL force IDLE and all outputs 0 within the same cycle, including mid-FETCH/MEM waits.
REQ-014 Release of rst SHALL not produce any strobe until start sampled 1.

Configuration
REQ-015 Macro CTRL_STACK_OPS_EN defined: PSH/POP decoded per REQ-008; undefined: PSH/POP treated as illegal (REQ-006) and sp_push/sp_pop tied 0.

Structure
REQ-016 Shared package ctrl_pkg SHALL hold opcode constants (NOP=000000, HLT=000001, LDA=000010, STA=000011, ADD=000100, SUB=000101, AND=000110, OR=000111, LDI=001000, JMP=010000, BRZ=010001, PSH=011000, POP=011001), state encoding, acc_src and alu_op codes.
REQ-017 One sub-module ctrl_decode (combinational opcode classifier: class, alu_op, legal) is natural; FSM stays in ctrl_fsm.

Verification
REQ-018 rst=0 mid-FETCH with mem_rd=1 -> all outputs 0 immediately, state IDLE; start pulse -> mem_rd=1 next cycle.
REQ-019 start, opcode=ADD, mem_ready=1 at once -> ir_w/pc_inc cycle 1, DECODE cycle 2, acc_w=1 alu_op=0 cycle 3, mem_rd=1 cycle 4.
REQ-020 opcode=LDA, mem_ready held 0 for 3 cycles in MEM -> mem_rd=1 addr_sel=1 stable 4 cycles, acc_w=1 acc_src=1 only in final cycle.
REQ-021 opcode=BRZ with zero=0 -> pc_load=0; zero=1 -> pc_load=1 for one cycle, no pc_inc that cycle.
REQ-022 opcode=111111 -> illegal=1 one cycle in DECODE, next state FETCH; opcode=PSH without CTRL_STACK_OPS_EN -> illegal=1, sp_push=0.
REQ-023 opcode=HLT -> halted=1 held 20 cycles with start toggling; rst=0 -> halted=0.
